// File: rtl/sbit_frame_sequencer_if.sv
// Handshake bundle between the S-bit frame sequencer and its byte-capture datapath.
// The master modport drives the control inputs; the slave modport is the sequencer side.
interface sbit_frame_sequencer_if;
   logic        enable;
   logic        sof;
   logic [2:0]  phase_ofs;
   logic        clear_cnt;
   logic [2:0]  byte_sel;
   logic [7:0]  byte_we;
   logic        frame_strobe;
   logic        locked;
   logic [7:0]  slip_cnt;
   logic [15:0] err_cnt;

   modport master (
      output enable, sof, phase_ofs, clear_cnt,
      input  byte_sel, byte_we, frame_strobe, locked, slip_cnt, err_cnt
   );

   modport slave (
      input  enable, sof, phase_ofs, clear_cnt,
      output byte_sel, byte_we, frame_strobe, locked, slip_cnt, err_cnt
   );
endinterface

// File: rtl/sbit_frame_sequencer.sv
// Byte-phase sequencer for the 8:1 S-bit deserializer: sof alignment, lock tracking, byte enables.
// Optional macro SBIT_FRAME_PHASE_OFS_EN moves the expected sof phase to phase_ofs (default: phase 0).
module sbit_frame_sequencer #(
   parameter int unsigned LOCK_CNT    = 4,
   parameter int unsigned UNLOCK_ERRS = 2
) (
   input  logic                  clock8x,
   input  logic                  reset_n,
   sbit_frame_sequencer_if.slave bus
);
   localparam logic [2:0] LAST_BYTE  = 3'd7;
   localparam logic [3:0] LOCK_TGT   = 4'(LOCK_CNT);
   localparam logic [3:0] UNLOCK_TGT = 4'(UNLOCK_ERRS);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEEK   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_LOCKED = 2'd3
   } state_t;

   state_t      state_r;
   logic [2:0]  bytecnt_r;
   logic [3:0]  good_r;
   logic [3:0]  miss_r;
   logic        locked_r;
   logic        frame_strobe_r;
   logic [7:0]  slip_cnt_r;
   logic [15:0] err_cnt_r;

   logic [2:0]  exp_s;
   logic        at_exp_s;
   logic        good_frame_s;
   logic        bad_frame_s;
   logic        slip_s;
   logic        err_inc_s;
   logic [3:0]  good_inc_s;
   logic [3:0]  miss_inc_s;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      if (v == 8'hFF) return v;
      else            return v + 8'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      if (v == 16'hFFFF) return v;
      else               return v + 16'd1;
   endfunction

`ifdef SBIT_FRAME_PHASE_OFS_EN
   logic [2:0] exp_r;

   // Expected sof phase, taken only at a frame boundary (or while idle) so a change lands on a whole frame.
   always_ff @(posedge clock8x or negedge reset_n) begin
      if (!reset_n) begin
         exp_r <= 3'd0;
      end else if ((state_r == ST_IDLE) || (bytecnt_r == LAST_BYTE)) begin
         exp_r <= bus.phase_ofs;
      end else begin
         exp_r <= exp_r;
      end
   end

   assign exp_s = exp_r;
`else
   logic unused_phase_ofs_s;
   assign unused_phase_ofs_s = ^bus.phase_ofs;
   assign exp_s = 3'd0;
`endif

   assign at_exp_s     = (bytecnt_r == exp_s);
   assign good_frame_s = bus.sof & at_exp_s;
   assign bad_frame_s  = at_exp_s ? ~bus.sof : bus.sof;
   assign slip_s       = bus.enable & (state_r == ST_SEEK) & bus.sof & ~at_exp_s;
   assign err_inc_s    = bus.enable & (state_r == ST_LOCKED) & bad_frame_s;
   assign good_inc_s   = good_r + 4'd1;
   assign miss_inc_s   = miss_r + 4'd1;

   // Phase counter, lock FSM and the registered lock flag.
   always_ff @(posedge clock8x or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         bytecnt_r <= 3'd0;
         good_r    <= 4'd0;
         miss_r    <= 4'd0;
         locked_r  <= 1'b0;
      end else if (!bus.enable) begin
         state_r   <= ST_IDLE;
         bytecnt_r <= 3'd0;
         good_r    <= 4'd0;
         miss_r    <= 4'd0;
         locked_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_r   <= ST_SEEK;
               bytecnt_r <= 3'd0;
               good_r    <= 4'd0;
               miss_r    <= 4'd0;
               locked_r  <= 1'b0;
            end
            ST_SEEK: begin
               miss_r   <= 4'd0;
               locked_r <= 1'b0;
               // A slip re-phases the counter so the sof cycle becomes the expected byte.
               if (slip_s) begin
                  bytecnt_r <= exp_s + 3'd1;
                  state_r   <= ST_VERIFY;
                  good_r    <= 4'd1;
               end else if (good_frame_s) begin
                  bytecnt_r <= bytecnt_r + 3'd1;
                  state_r   <= ST_VERIFY;
                  good_r    <= 4'd1;
               end else begin
                  bytecnt_r <= bytecnt_r + 3'd1;
               end
            end
            ST_VERIFY: begin
               bytecnt_r <= bytecnt_r + 3'd1;
               if (good_frame_s) begin
                  good_r <= good_inc_s;
                  if (good_inc_s >= LOCK_TGT) begin
                     state_r  <= ST_LOCKED;
                     miss_r   <= 4'd0;
                     locked_r <= 1'b1;
                  end
               end else if (bad_frame_s) begin
                  state_r <= ST_SEEK;
                  good_r  <= 4'd0;
               end
            end
            ST_LOCKED: begin
               bytecnt_r <= bytecnt_r + 3'd1;
               if (good_frame_s) begin
                  miss_r <= 4'd0;
               end else if (bad_frame_s) begin
                  if (miss_inc_s >= UNLOCK_TGT) begin
                     state_r  <= ST_SEEK;
                     miss_r   <= 4'd0;
                     good_r   <= 4'd0;
                     locked_r <= 1'b0;
                  end else begin
                     miss_r <= miss_inc_s;
                  end
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               bytecnt_r <= 3'd0;
               good_r    <= 4'd0;
               miss_r    <= 4'd0;
               locked_r  <= 1'b0;
            end
         endcase
      end
   end

   // Saturating slip/error counters; clear_cnt wins over a same-cycle increment.
   always_ff @(posedge clock8x or negedge reset_n) begin
      if (!reset_n) begin
         slip_cnt_r <= 8'd0;
         err_cnt_r  <= 16'd0;
      end else if (bus.clear_cnt) begin
         slip_cnt_r <= 8'd0;
         err_cnt_r  <= 16'd0;
      end else begin
         if (slip_s)    slip_cnt_r <= sat_inc8(slip_cnt_r);
         if (err_inc_s) err_cnt_r  <= sat_inc16(err_cnt_r);
      end
   end

   // Frame-complete strobe, one cycle after the last byte of a locked frame.
   always_ff @(posedge clock8x or negedge reset_n) begin
      if (!reset_n) begin
         frame_strobe_r <= 1'b0;
      end else begin
         frame_strobe_r <= bus.enable & locked_r & (bytecnt_r == LAST_BYTE);
      end
   end

   assign bus.byte_sel     = bytecnt_r;
   assign bus.byte_we      = (state_r != ST_IDLE) ? (8'd1 << bytecnt_r) : 8'd0;
   assign bus.frame_strobe = frame_strobe_r;
   assign bus.locked       = locked_r;
   assign bus.slip_cnt     = slip_cnt_r;
   assign bus.err_cnt      = err_cnt_r;
endmodule

// File: tb/tb_sbit_frame_sequencer.sv
// Directed bench for sbit_frame_sequencer: a vector table for lock/unlock/enable behaviour
// plus hand sequences for async reset, counter saturation/clear and the phase-offset option.
module tb_sbit_frame_sequencer;
   logic clock8x = 1'b0;
   logic reset_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   sbit_frame_sequencer_if bus ();

   sbit_frame_sequencer #(.LOCK_CNT(4), .UNLOCK_ERRS(2)) dut (
      .clock8x (clock8x),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock8x = ~clock8x;

   typedef struct {
      logic        en;
      logic        sof;
      logic        clr;
      int          reps;
      logic [2:0]  sel;
      logic [7:0]  we;
      logic        stb;
      logic        lck;
      logic [7:0]  slip;
      logic [15:0] err;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic en, input logic sof, input int reps, input logic [2:0] sel,
                               input logic [7:0] we, input logic stb, input logic lck,
                               input logic [7:0] slip, input logic [15:0] err);
      vec_t v;
      v.en = en; v.sof = sof; v.clr = 1'b0; v.reps = reps; v.sel = sel; v.we = we;
      v.stb = stb; v.lck = lck; v.slip = slip; v.err = err;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [2:0] sel, input logic [7:0] we, input logic stb,
                            input logic lck, input logic [7:0] slip, input logic [15:0] err);
      check({tag, ".byte_sel"}, 16'(bus.byte_sel), 16'(sel));
      check({tag, ".byte_we"}, 16'(bus.byte_we), 16'(we));
      check({tag, ".frame_strobe"}, 16'(bus.frame_strobe), 16'(stb));
      check({tag, ".locked"}, 16'(bus.locked), 16'(lck));
      check({tag, ".slip_cnt"}, 16'(bus.slip_cnt), 16'(slip));
      check({tag, ".err_cnt"}, bus.err_cnt, err);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock8x);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] exp_sel_ofs;
      logic [7:0] exp_slip_ofs;

      bus.enable = 1'b0; bus.sof = 1'b0; bus.phase_ofs = 3'd0; bus.clear_cnt = 1'b0;

      // Reset/idle, lock from a sof at byte 5, strobes, unlock, enable drop at byte 3, relock.
      add(1'b0,1'b0,20, 3'd0,8'h00,1'b0,1'b0,8'd0,16'd0);
      add(1'b1,1'b0, 1, 3'd0,8'h01,1'b0,1'b0,8'd0,16'd0);
      add(1'b1,1'b0, 5, 3'd5,8'h20,1'b0,1'b0,8'd0,16'd0);
      add(1'b1,1'b1, 1, 3'd1,8'h02,1'b0,1'b0,8'd1,16'd0);
      for (int f = 0; f < 3; f++) begin
         add(1'b1,1'b0, 7, 3'd0,8'h01,1'b0,1'b0,8'd1,16'd0);
         add(1'b1,1'b1, 1, 3'd1,8'h02,1'b0,(f == 2),8'd1,16'd0);
      end
      add(1'b1,1'b0, 6, 3'd7,8'h80,1'b0,1'b1,8'd1,16'd0);
      add(1'b1,1'b0, 1, 3'd0,8'h01,1'b1,1'b1,8'd1,16'd0);
      add(1'b1,1'b1, 1, 3'd1,8'h02,1'b0,1'b1,8'd1,16'd0);
      add(1'b1,1'b0, 6, 3'd7,8'h80,1'b0,1'b1,8'd1,16'd0);
      add(1'b1,1'b0, 1, 3'd0,8'h01,1'b1,1'b1,8'd1,16'd0);
      add(1'b1,1'b0, 1, 3'd1,8'h02,1'b0,1'b1,8'd1,16'd1);
      add(1'b1,1'b0, 6, 3'd7,8'h80,1'b0,1'b1,8'd1,16'd1);
      add(1'b1,1'b0, 1, 3'd0,8'h01,1'b1,1'b1,8'd1,16'd1);
      add(1'b1,1'b1, 1, 3'd1,8'h02,1'b0,1'b1,8'd1,16'd1);
      add(1'b1,1'b0, 7, 3'd0,8'h01,1'b1,1'b1,8'd1,16'd1);
      add(1'b1,1'b0, 1, 3'd1,8'h02,1'b0,1'b1,8'd1,16'd2);
      add(1'b1,1'b0, 7, 3'd0,8'h01,1'b1,1'b1,8'd1,16'd2);
      add(1'b1,1'b0, 1, 3'd1,8'h02,1'b0,1'b0,8'd1,16'd3);
      add(1'b1,1'b0, 7, 3'd0,8'h01,1'b0,1'b0,8'd1,16'd3);
      add(1'b1,1'b1, 1, 3'd1,8'h02,1'b0,1'b0,8'd1,16'd3);
      for (int f = 0; f < 3; f++) begin
         add(1'b1,1'b0, 7, 3'd0,8'h01,1'b0,1'b0,8'd1,16'd3);
         add(1'b1,1'b1, 1, 3'd1,8'h02,1'b0,(f == 2),8'd1,16'd3);
      end
      add(1'b1,1'b0, 2, 3'd3,8'h08,1'b0,1'b1,8'd1,16'd3);
      add(1'b0,1'b0, 1, 3'd0,8'h00,1'b0,1'b0,8'd1,16'd3);
      add(1'b1,1'b0, 1, 3'd0,8'h01,1'b0,1'b0,8'd1,16'd3);
      add(1'b1,1'b1, 1, 3'd1,8'h02,1'b0,1'b0,8'd1,16'd3);
      for (int f = 0; f < 3; f++) begin
         add(1'b1,1'b0, 7, 3'd0,8'h01,1'b0,1'b0,8'd1,16'd3);
         add(1'b1,1'b1, 1, 3'd1,8'h02,1'b0,(f == 2),8'd1,16'd3);
      end

      tick(3);
      reset_n = 1'b1;
      check_all("reset", 3'd0, 8'h00, 1'b0, 1'b0, 8'd0, 16'd0);

      foreach (vecs[i]) begin
         bus.enable    = vecs[i].en;
         bus.sof       = vecs[i].sof;
         bus.clear_cnt = vecs[i].clr;
         tick(vecs[i].reps);
         check_all($sformatf("vec%0d", i), vecs[i].sel, vecs[i].we, vecs[i].stb,
                   vecs[i].lck, vecs[i].slip, vecs[i].err);
      end

      // Asynchronous reset in the middle of a locked frame.
      bus.sof = 1'b0;
      tick(5);
      check_all("pre_reset", 3'd6, 8'h40, 1'b0, 1'b1, 8'd1, 16'd3);
      #2;
      reset_n = 1'b0;
      bus.enable = 1'b0;
      #1;
      check_all("async_reset", 3'd0, 8'h00, 1'b0, 1'b0, 8'd0, 16'd0);
      @(posedge clock8x);
      #1;
      reset_n = 1'b1;
      tick(3);
      check_all("post_reset", 3'd0, 8'h00, 1'b0, 1'b0, 8'd0, 16'd0);

      // 300 slips (sof held high alternates SEEK slip / VERIFY bad), then clear on a slip cycle.
      bus.enable = 1'b1;
      tick(2);
      check_all("sat_start", 3'd1, 8'h02, 1'b0, 1'b0, 8'd0, 16'd0);
      bus.sof = 1'b1;
      tick(600);
      check_all("slip_sat", 3'd2, 8'h04, 1'b0, 1'b0, 8'd255, 16'd0);
      bus.clear_cnt = 1'b1;
      tick(1);
      check_all("clear_on_slip", 3'd1, 8'h02, 1'b0, 1'b0, 8'd0, 16'd0);
      bus.clear_cnt = 1'b0;
      bus.sof = 1'b0;

      // Phase offset 3 with sof at byte 3: aligned when the option is built in, one slip otherwise.
`ifdef SBIT_FRAME_PHASE_OFS_EN
      exp_sel_ofs = 3'd4; exp_slip_ofs = 8'd0;
`else
      exp_sel_ofs = 3'd1; exp_slip_ofs = 8'd1;
`endif
      reset_n = 1'b0;
      bus.enable = 1'b0;
      bus.phase_ofs = 3'd3;
      tick(1);
      reset_n = 1'b1;
      tick(2);
      bus.enable = 1'b1;
      tick(1);
      tick(3);
      check("ofs_pre.byte_sel", 16'(bus.byte_sel), 16'd3);
      bus.sof = 1'b1;
      tick(1);
      check_all("ofs_first", exp_sel_ofs, 8'd1 << exp_sel_ofs, 1'b0, 1'b0, exp_slip_ofs, 16'd0);
      for (int f = 0; f < 3; f++) begin
         bus.sof = 1'b0;
         tick(7);
         bus.sof = 1'b1;
         tick(1);
         check_all($sformatf("ofs_frame%0d", f), exp_sel_ofs, 8'd1 << exp_sel_ofs, 1'b0,
                   (f == 2), exp_slip_ofs, 16'd0);
      end
      bus.sof = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
